// File: rtl/agc_pkg.sv
// AGC stepping engine: shared types, constants and the saturating step helper.
package agc_pkg;

  localparam int GAIN_W       = 6;
  localparam int MAX_GAIN_DEF = 38;
  localparam int COARSE_STEP  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_LOCKED
  } agc_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } agc_dir_e;

  // Clamp to [0, mx]; never wraps in either direction.
  function automatic logic [GAIN_W-1:0] gain_step(
    input logic [GAIN_W-1:0] g,
    input logic [2:0]        s,
    input logic              up,
    input logic [GAIN_W-1:0] mx
  );
    logic [GAIN_W:0]   sum;
    logic [GAIN_W-1:0] s_w;
    s_w = {{(GAIN_W-3){1'b0}}, s};
    sum = {1'b0, g} + {1'b0, s_w};
    if (up) begin
      return (sum > {1'b0, mx}) ? mx : sum[GAIN_W-1:0];
    end
    return (g < s_w) ? '0 : g - s_w;
  endfunction

endpackage

// File: rtl/agc_peak_counter.sv
// Measurement window counter with peak_high / peak_low occurrence counters.
module agc_peak_counter #(
  parameter  int MEAS_CYC = 32,
  localparam int CW       = $clog2(MEAS_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          cnt_en_i,
  input  logic          peak_high_i,
  input  logic          peak_low_i,
  output logic [CW-1:0] hi_cnt_o,
  output logic [CW-1:0] lo_cnt_o,
  output logic          done_o
);

  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] lo_q, lo_d;

  assign done_o   = cnt_en_i && (win_q == CW'(MEAS_CYC - 1));
  assign hi_cnt_o = hi_q;
  assign lo_cnt_o = lo_q;

  always_comb begin
    win_d = win_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (clr_i) begin
      win_d = '0;
      hi_d  = '0;
      lo_d  = '0;
    end else if (cnt_en_i) begin
      win_d = done_o ? '0 : win_q + CW'(1);
      if (peak_high_i) begin
        hi_d = hi_q + CW'(1);
      end else if (peak_low_i) begin
        // high wins when both comparators fire together
        lo_d = lo_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      win_q <= win_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/agc_gain_controller.sv
// Closed-loop AGC gain index stepper: settle, measure, decide, lock.
// Define AGC_COARSE_STEP_EN for step=4 acquisition until first reversal/hold.
module agc_gain_controller
  import agc_pkg::*;
#(
  parameter int MAX_GAIN   = MAX_GAIN_DEF,
  parameter int INIT_GAIN  = 38,
  parameter int SETTLE_CYC = 16,
  parameter int MEAS_CYC   = 32,
  parameter int HI_TRIG    = 2,
  parameter int LOCK_CNT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              peak_high,
  input  logic              peak_low,
  output logic [GAIN_W-1:0] gain_array,
  output logic              gain_update,
  output logic              locked
);

  localparam int CW = $clog2(MEAS_CYC + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int HW = $clog2(LOCK_CNT + 1);

  localparam logic [GAIN_W-1:0] GMAX  = GAIN_W'(MAX_GAIN);
  localparam logic [GAIN_W-1:0] GINIT = GAIN_W'(INIT_GAIN);

  agc_state_e        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              upd_q, upd_d;
  logic              lock_q, lock_d;
  logic [SW-1:0]     set_q, set_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [CW-1:0]     hi_cnt, lo_cnt;
  logic              pc_done, pc_clr, pc_en;
  logic              dec, inc;
  logic [2:0]        step;
  logic [GAIN_W-1:0] target;

  agc_peak_counter #(
    .MEAS_CYC (MEAS_CYC)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pc_clr),
    .cnt_en_i    (pc_en),
    .peak_high_i (peak_high),
    .peak_low_i  (peak_low),
    .hi_cnt_o    (hi_cnt),
    .lo_cnt_o    (lo_cnt),
    .done_o      (pc_done)
  );

  assign dec = hi_cnt >= CW'(HI_TRIG);
  assign inc = !dec && (lo_cnt == CW'(MEAS_CYC));

`ifdef AGC_COARSE_STEP_EN
  logic     coarse_q, coarse_d;
  agc_dir_e dir_q, dir_d;
  logic     rev;

  // the reversing step itself is already a fine step
  assign rev  = (dec && dir_q == DIR_UP) || (inc && dir_q == DIR_DN);
  assign step = (coarse_q && !rev) ? 3'(COARSE_STEP) : 3'd1;
`else
  assign step = 3'd1;
`endif

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    upd_d   = 1'b0;
    lock_d  = lock_q;
    set_d   = set_q;
    hold_d  = hold_q;
    pc_clr  = 1'b1;
    pc_en   = 1'b0;
    target  = gain_q;
`ifdef AGC_COARSE_STEP_EN
    coarse_d = coarse_q;
    dir_d    = dir_q;
`endif
    if (restart) begin
      gain_d  = GINIT;
      upd_d   = (gain_q != GINIT);
      lock_d  = 1'b0;
      set_d   = '0;
      hold_d  = '0;
      state_d = en ? S_SETTLE : S_IDLE;
`ifdef AGC_COARSE_STEP_EN
      coarse_d = 1'b1;
      dir_d    = DIR_NONE;
`endif
    end else if (!en) begin
      state_d = S_IDLE;
      lock_d  = 1'b0;
      set_d   = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          set_d   = '0;
        end
        S_SETTLE: begin
          if (set_q == SW'(SETTLE_CYC - 1)) begin
            set_d   = '0;
            state_d = S_MEASURE;
          end else begin
            set_d = set_q + SW'(1);
          end
        end
        S_MEASURE: begin
          pc_clr = 1'b0;
          pc_en  = 1'b1;
          if (pc_done) state_d = S_DECIDE;
        end
        S_DECIDE: begin
          if (dec) begin
            target = gain_step(gain_q, step, 1'b0, GMAX);
          end else if (inc) begin
            target = gain_step(gain_q, step, 1'b1, GMAX);
          end
          if (target != gain_q) begin
            gain_d  = target;
            upd_d   = 1'b1;
            hold_d  = '0;
            set_d   = '0;
            state_d = S_SETTLE;
`ifdef AGC_COARSE_STEP_EN
            if (rev) coarse_d = 1'b0;
            dir_d = dec ? DIR_DN : DIR_UP;
`endif
          end else begin
            hold_d = hold_q + HW'(1);
`ifdef AGC_COARSE_STEP_EN
            coarse_d = 1'b0;
`endif
            if (hold_d == HW'(LOCK_CNT)) begin
              state_d = S_LOCKED;
              lock_d  = 1'b1;
            end else begin
              state_d = S_MEASURE;
            end
          end
        end
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gain_q  <= GINIT;
      upd_q   <= 1'b0;
      lock_q  <= 1'b0;
      set_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      upd_q   <= upd_d;
      lock_q  <= lock_d;
      set_q   <= set_d;
      hold_q  <= hold_d;
    end
  end

`ifdef AGC_COARSE_STEP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      coarse_q <= 1'b1;
      dir_q    <= DIR_NONE;
    end else begin
      coarse_q <= coarse_d;
      dir_q    <= dir_d;
    end
  end
`endif

  assign gain_array  = gain_q;
  assign gain_update = upd_q;
  assign locked      = lock_q;

endmodule

// File: tb/tb_agc_gain_controller.sv
// Scoreboard bench for agc_gain_controller: expected update/lock events
// with their cycle stamps are queued by the stimulus and popped by a monitor.
module tb_agc_gain_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic       peak_high = 1'b0;
  logic       peak_low = 1'b0;
  logic [5:0] gain_array;
  logic       gain_update;
  logic       locked;

  typedef struct {
    bit lk;
    int gain;
    int at;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  mode = 0;
  int  max_seen = 0;
  bit  lk_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  agc_gain_controller #(
    .MAX_GAIN   (38),
    .INIT_GAIN  (38),
    .SETTLE_CYC (4),
    .MEAS_CYC   (8),
    .HI_TRIG    (2),
    .LOCK_CNT   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .restart     (restart),
    .peak_high   (peak_high),
    .peak_low    (peak_low),
    .gain_array  (gain_array),
    .gain_update (gain_update),
    .locked      (locked)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit lk, input int g, input int rel);
    ev_t e;
    e.lk = lk;
    e.gain = g;
    e.at = t0 + rel;
    q.push_back(e);
  endtask

  function automatic void drive();
    case (mode)
      1: begin peak_high = 1'b1; peak_low = 1'b0; end
      2: begin peak_high = 1'b0; peak_low = 1'b1; end
      3: begin
        peak_high = (cyc % 9 == 0);
        peak_low  = cyc[0];
      end
      default: begin peak_high = 1'b0; peak_low = 1'b0; end
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    drive();
  endtask

  task automatic setmode(input int m);
    mode = m;
    drive();
  endtask

  task automatic wait_rel(input int r);
    while (cyc < t0 + r) tick();
  endtask

  task automatic drain(input int mx);
    int n = 0;
    while (q.size() != 0 && n < mx) begin
      tick();
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d events still pending after %0d cycles",
               q.size(), mx);
      q.delete();
    end
  endtask

  task automatic got(input bit lk, input int g);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: gain=%0d at cyc %0d, none required",
               lk ? "lock" : "update", g, cyc);
    end else begin
      e = q.pop_front();
      if (e.lk != lk || e.gain != g || e.at != cyc) begin
        fails++;
        $display("FAIL event: got lock=%0d gain=%0d cyc=%0d required lock=%0d gain=%0d cyc=%0d",
                 lk, g, cyc, e.lk, e.gain, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(gain_array) > max_seen) max_seen = int'(gain_array);
      if (gain_update === 1'b1) got(1'b0, int'(gain_array));
      if (locked === 1'b1 && !lk_prev) got(1'b1, int'(gain_array));
      lk_prev = (locked === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_gain", int'(gain_array), 38);
    chk("rst_upd", int'(gain_update), 0);
    chk("rst_lock", int'(locked), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_gain", int'(gain_array), 38);
      chk("idle_upd", int'(gain_update), 0);
      chk("idle_lock", int'(locked), 0);
    end

    // constant peak_high: walk down to 0, saturate, lock
    en = 1'b1;
    setmode(1);
    t0 = cyc;
    for (int k = 1; k <= 38; k++) push(1'b0, 38 - k, 1 + 13 * k);
    push(1'b1, 0, 526);
    drain(600);
    repeat (15) tick();

    // en low leaves gain; restart reloads, then climb back with peak_low
    en = 1'b0;
    tick();
    chk("en0_lock", int'(locked), 0);
    chk("en0_gain", int'(gain_array), 0);
    en = 1'b1;
    restart = 1'b1;
    t0 = cyc;
    push(1'b0, 38, 1);
    push(1'b0, 37, 14);
    push(1'b0, 36, 27);
    push(1'b0, 35, 40);
    tick();
    restart = 1'b0;
    wait_rel(40);
    setmode(2);
    push(1'b0, 36, 53);
    push(1'b0, 37, 66);
    push(1'b0, 38, 79);
    push(1'b1, 38, 110);
    drain(120);
    repeat (15) tick();

    // restart out of LOCKED with unchanged gain: no pulse; quiet inputs lock
    setmode(0);
    restart = 1'b1;
    t0 = cyc;
    push(1'b1, 38, 32);
    tick();
    restart = 1'b0;
    chk("rs_unlock", int'(locked), 0);
    chk("rs_nopulse", int'(gain_update), 0);
    drain(60);
    repeat (10) tick();

    // two decrements, then sparse high + partial low: hold and lock at 36
    en = 1'b0;
    tick();
    en = 1'b1;
    setmode(1);
    t0 = cyc;
    push(1'b0, 37, 14);
    push(1'b0, 36, 27);
    wait_rel(27);
    setmode(3);
    push(1'b1, 36, 58);
    drain(60);
    repeat (10) tick();

    // en dropped mid-MEASURE of the second window
    en = 1'b0;
    tick();
    chk("drop_lock", int'(locked), 0);
    en = 1'b1;
    setmode(0);
    t0 = cyc;
    wait_rel(20);
    en = 1'b0;
    tick();
    chk("abort_gain", int'(gain_array), 36);
    chk("abort_lock", int'(locked), 0);
    chk("abort_upd", int'(gain_update), 0);
    repeat (3) tick();
    en = 1'b1;
    t0 = cyc;
    push(1'b1, 36, 32);
    drain(60);
    repeat (10) tick();

    // descend to 20, then restart: single pulse back to 38
    en = 1'b0;
    tick();
    en = 1'b1;
    restart = 1'b1;
    setmode(1);
    t0 = cyc;
    push(1'b0, 38, 1);
    for (int k = 1; k <= 18; k++) push(1'b0, 38 - k, 1 + 13 * k);
    tick();
    restart = 1'b0;
    wait_rel(235);
    chk("pre_rs_gain", int'(gain_array), 20);
    setmode(0);
    restart = 1'b1;
    t0 = cyc;
    push(1'b0, 38, 1);
    push(1'b1, 38, 32);
    tick();
    restart = 1'b0;
    drain(60);
    repeat (15) tick();

    chk("max_gain_le_38", int'(max_seen <= 38), 1);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
